// File: rtl/asap_pkg.sv
// asap_pkg: opcodes, T-state constants and control-word bit layout for the bus machine sequencer
package asap_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam int CW_PC_OE   = 0;
  localparam int CW_PC_INC  = 1;
  localparam int CW_PC_LD   = 2;
  localparam int CW_MAR_IN  = 3;
  localparam int CW_RAM_OE  = 4;
  localparam int CW_RAM_IN  = 5;
  localparam int CW_IR_IN   = 6;
  localparam int CW_IR_OE   = 7;
  localparam int CW_A_IN    = 8;
  localparam int CW_A_OE    = 9;
  localparam int CW_B_IN    = 10;
  localparam int CW_ALU_OE  = 11;
  localparam int CW_SUB     = 12;
  localparam int CW_OUT_IN  = 13;
  localparam int CW_HLT     = 14;
  // internal bits: flag capture and end-of-instruction marker
  localparam int CW_FL_LD   = 15;
  localparam int CW_LAST    = 16;
  localparam int CW_W       = 17;
  typedef logic [CW_W-1:0] cw_t;
  function automatic cw_t cw_bit(input int i);
    return cw_t'(1) << i;
  endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: maps (step, opcode, flags) to the control word; jumps only when CTRL_JUMP_EN is defined
module control_decode import asap_pkg::*; #(
  parameter int STEP_W = 3
) (
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        opcode,
  input  logic              zf_q,
  input  logic              cf_q,
  output cw_t               cw
);
  always_comb begin
    cw = '0;
    case (step)
      STEP_W'(T0): cw = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_IN);
      STEP_W'(T1): cw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_INC);
      STEP_W'(T2):
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_IN);
          OP_LDI: cw = cw_bit(CW_IR_OE) | cw_bit(CW_A_IN) | cw_bit(CW_LAST);
`ifdef CTRL_JUMP_EN
          OP_JMP: cw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_LD) | cw_bit(CW_LAST);
          OP_JC:  cw = cw_bit(CW_IR_OE) | cw_bit(CW_LAST) | (cf_q ? cw_bit(CW_PC_LD) : '0);
          OP_JZ:  cw = cw_bit(CW_IR_OE) | cw_bit(CW_LAST) | (zf_q ? cw_bit(CW_PC_LD) : '0);
`endif
          OP_OUT: cw = cw_bit(CW_A_OE) | cw_bit(CW_OUT_IN) | cw_bit(CW_LAST);
          OP_HLT: cw = cw_bit(CW_HLT);
          default: cw = cw_bit(CW_LAST);
        endcase
      STEP_W'(T3):
        case (opcode)
          OP_LDA: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_A_IN) | cw_bit(CW_LAST);
          OP_ADD: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IN);
          OP_SUB: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IN) | cw_bit(CW_SUB);
          OP_STA: cw = cw_bit(CW_A_OE) | cw_bit(CW_RAM_IN) | cw_bit(CW_LAST);
          default: cw = cw_bit(CW_LAST);
        endcase
      STEP_W'(T4):
        case (opcode)
          OP_ADD: cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IN) | cw_bit(CW_FL_LD) | cw_bit(CW_LAST);
          OP_SUB: cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IN) | cw_bit(CW_FL_LD) | cw_bit(CW_SUB) | cw_bit(CW_LAST);
          default: cw = cw_bit(CW_LAST);
        endcase
      default: cw = '0;
    endcase
  end
`ifndef CTRL_JUMP_EN
  logic w_unused;
  assign w_unused = zf_q ^ cf_q;
`endif
endmodule

// File: rtl/control_unit.sv
// control_unit: T-state sequencer, halt latch, flag register and reset forcing of the control word
// CTRL_JUMP_EN enables JMP/JC/JZ and the flag register.
module control_unit import asap_pkg::*; #(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              zf,
  input  logic              cf,
  output logic              pc_oe,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic              mar_in,
  output logic              ram_oe,
  output logic              ram_in,
  output logic              ir_in,
  output logic              ir_oe,
  output logic              a_in,
  output logic              a_oe,
  output logic              b_in,
  output logic              alu_oe,
  output logic              sub,
  output logic              out_in,
  output logic              hlt,
  output logic [STEP_W-1:0] step,
  output logic              zf_q,
  output logic              cf_q
);
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic              r_halt, w_zf_q, w_cf_q;
  cw_t               w_cw_dec;
  logic [CW_HLT:0]   w_cw;
  control_decode #(.STEP_W(STEP_W)) u_dec (
    .step   (r_step),
    .opcode (opcode),
    .zf_q   (w_zf_q),
    .cf_q   (w_cf_q),
    .cw     (w_cw_dec)
  );
  // once halted, only hlt is driven regardless of what opcode does afterwards
  always_comb begin
    w_cw = rst ? '0 : r_halt ? CW_HLT'(1) << CW_HLT : w_cw_dec[CW_HLT:0];
    w_step_nxt = (r_halt || w_cw_dec[CW_HLT]) ? r_step :
                 (w_cw_dec[CW_LAST] || r_step >= STEP_W'(T4)) ? STEP_W'(T0) : r_step + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      r_halt <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      r_halt <= r_halt | w_cw_dec[CW_HLT];
    end
  end
`ifdef CTRL_JUMP_EN
  logic r_zf, r_cf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b0;
      r_cf <= 1'b0;
    end else if (w_cw_dec[CW_FL_LD] && !r_halt) begin
      r_zf <= zf;
      r_cf <= cf;
    end
  end
  assign w_zf_q = r_zf;
  assign w_cf_q = r_cf;
  assign pc_ld  = w_cw[CW_PC_LD];
`else
  logic w_unused;
  assign w_unused = zf ^ cf ^ w_cw_dec[CW_FL_LD] ^ w_cw[CW_PC_LD];
  assign w_zf_q = 1'b0;
  assign w_cf_q = 1'b0;
  assign pc_ld  = 1'b0;
`endif
  assign pc_oe  = w_cw[CW_PC_OE];
  assign pc_inc = w_cw[CW_PC_INC];
  assign mar_in = w_cw[CW_MAR_IN];
  assign ram_oe = w_cw[CW_RAM_OE];
  assign ram_in = w_cw[CW_RAM_IN];
  assign ir_in  = w_cw[CW_IR_IN];
  assign ir_oe  = w_cw[CW_IR_OE];
  assign a_in   = w_cw[CW_A_IN];
  assign a_oe   = w_cw[CW_A_OE];
  assign b_in   = w_cw[CW_B_IN];
  assign alu_oe = w_cw[CW_ALU_OE];
  assign sub    = w_cw[CW_SUB];
  assign out_in = w_cw[CW_OUT_IN];
  assign hlt    = w_cw[CW_HLT];
  assign step   = r_step;
  assign zf_q   = w_zf_q;
  assign cf_q   = w_cf_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives the sequencer with a small bus datapath and checks it against an instruction-level model
module tb_control_unit;
`ifdef CTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif
  localparam logic [14:0] S_PC_OE = 15'h0001, S_PC_INC = 15'h0002, S_PC_LD = 15'h0004,
    S_MAR_IN = 15'h0008, S_RAM_OE = 15'h0010, S_RAM_IN = 15'h0020, S_IR_IN = 15'h0040,
    S_IR_OE = 15'h0080, S_A_IN = 15'h0100, S_A_OE = 15'h0200, S_B_IN = 15'h0400,
    S_ALU_OE = 15'h0800, S_SUB = 15'h1000, S_OUT_IN = 15'h2000, S_HLT = 15'h4000;
  localparam logic [14:0] OE_M = S_PC_OE | S_RAM_OE | S_IR_OE | S_A_OE | S_ALU_OE;
  localparam logic [14:0] W_T0 = S_PC_OE | S_MAR_IN;
  localparam logic [14:0] W_T1 = S_RAM_OE | S_IR_IN | S_PC_INC;
  localparam logic [14:0] W_MEM = S_IR_OE | S_MAR_IN;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] opcode;
  logic zf, cf, pc_oe, pc_inc, pc_ld, mar_in, ram_oe, ram_in, ir_in, ir_oe;
  logic a_in, a_oe, b_in, alu_oe, sub, out_in, hlt, zf_q, cf_q;
  logic [2:0] step;
  int total = 0, bad = 0;
  control_unit #(.STEP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .cf(cf),
    .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_ld(pc_ld), .mar_in(mar_in),
    .ram_oe(ram_oe), .ram_in(ram_in), .ir_in(ir_in), .ir_oe(ir_oe),
    .a_in(a_in), .a_oe(a_oe), .b_in(b_in), .alu_oe(alu_oe), .sub(sub),
    .out_in(out_in), .hlt(hlt), .step(step), .zf_q(zf_q), .cf_q(cf_q)
  );
  always #5 clk = ~clk;
  // bus datapath: PC, MAR, 16-byte RAM, IR, A, B, ALU, output register
  logic [3:0] pc, mar;
  logic [7:0] mem [16], prog [16], ir, a, b, out_r, bus;
  logic [8:0] alu;
  assign opcode = ir[7:4];
  assign zf = alu[7:0] == 8'h00;
  assign cf = alu[8];
  always_comb begin
    alu = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    bus = pc_oe ? {4'h0, pc} : ram_oe ? mem[mar] : ir_oe ? {4'h0, ir[3:0]} :
          a_oe ? a : alu_oe ? alu[7:0] : 8'h00;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= prog; pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; a <= 8'h00; b <= 8'h00; out_r <= 8'h00;
    end else begin
      if (mar_in) mar <= bus[3:0];
      if (ram_in) mem[mar] <= bus;
      if (ir_in) ir <= bus;
      if (a_in) a <= bus;
      if (b_in) b <= bus;
      if (out_in) out_r <= bus;
      if (pc_ld) pc <= bus[3:0];
      else if (pc_inc) pc <= pc + 4'h1;
    end
  end
  function automatic logic [14:0] strobes();
    return {hlt, out_in, sub, alu_oe, b_in, a_oe, a_in, ir_oe, ir_in, ram_in, ram_oe, mar_in, pc_ld, pc_inc, pc_oe};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                      input logic [7:0] pe, input logic [7:0] pf);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[14] = pe; prog[15] = pf;
    do_reset();
  endtask
  logic [14:0] cap [8];
  logic [2:0]  stp [8];
  // runs one instruction from T0 until the step counter returns to T0 or hlt appears
  task automatic exec(output int len, output bit halted);
    len = 0;
    halted = 1'b0;
    do begin
      cap[len] = strobes();
      stp[len] = step;
      chk("one_bus_driver", 32'($countones(strobes() & OE_M) <= 1), 1);
      if (hlt) halted = 1'b1;
      len++;
      @(negedge clk);
    end while (step != 3'd0 && len < 8 && !halted);
    if (!halted && step != 3'd0) begin
      total++; bad++;
      $display("FAIL exec_bound: step %0d after %0d cycles, required return to 0", step, len);
    end
  endtask
  typedef struct { logic [7:0] ins; int len; logic [14:0] t2; } vec_t;
  vec_t tbl [15];
  logic [7:0] m [16];
  initial begin
    int len, elen, t;
    bit halted, ih;
    logic [3:0] ipc, n;
    logic [7:0] ia, iout, ins;
    logic iz, ic;
    logic [3:0] ops [12];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    tbl = '{'{8'h00, 3, 15'h0}, '{8'h1E, 4, W_MEM}, '{8'h2E, 5, W_MEM}, '{8'h3E, 5, W_MEM},
            '{8'h4E, 4, W_MEM}, '{8'h55, 3, S_IR_OE | S_A_IN},
            '{8'h63, 3, JEN ? S_IR_OE | S_PC_LD : 15'h0}, '{8'h77, 3, JEN ? S_IR_OE : 15'h0},
            '{8'h83, 3, JEN ? S_IR_OE : 15'h0}, '{8'hA0, 3, 15'h0}, '{8'hB1, 3, 15'h0},
            '{8'hC2, 3, 15'h0}, '{8'hD3, 3, 15'h0}, '{8'hE0, 3, S_A_OE | S_OUT_IN}, '{8'hF0, 3, S_HLT}};
    do_reset();
    chk("reset_step", step, 0);
    chk("reset_flags", {zf_q, cf_q}, 0);
    for (int i = 0; i < 15; i++) begin
      load(tbl[i].ins, 8'h00, 8'h00, 8'h00, 8'h00);
      exec(len, halted);
      chk($sformatf("len_%h", tbl[i].ins), len, tbl[i].len);
      chk($sformatf("t0_%h", tbl[i].ins), cap[0], W_T0);
      chk($sformatf("t1_%h", tbl[i].ins), cap[1], W_T1);
      chk($sformatf("t2_%h", tbl[i].ins), cap[2], tbl[i].t2);
    end
    // reset in the middle of ADD at T3
    load(8'h2E, 8'h00, 8'h00, 8'h03, 8'h00);
    for (int i = 0; i < 10 && step != 3'd3; i++) @(negedge clk);
    chk("reach_t3", step, 3);
    rst = 1'b1;
    #1;
    chk("midrst_step", step, 0);
    chk("midrst_strobes", strobes(), 0);
    @(negedge clk);
    chk("midrst_hold", strobes(), 0);
    rst = 1'b0;
    #1;
    chk("release_t0", strobes(), W_T0);
    exec(len, halted);
    chk("add_after_rst_len", len, 5);
    chk("add_after_rst_a", a, 3);
    // LDA 0xE
    load(8'h1E, 8'h00, 8'h00, 8'h5A, 8'h00);
    exec(len, halted);
    chk("lda_len", len, 4);
    chk("lda_steps", {stp[0], stp[1], stp[2], stp[3], step}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});
    chk("lda_t3", cap[3], S_RAM_OE | S_A_IN);
    chk("lda_a", a, 8'h5A);
    // 5-5 sets zero, JZ follows it
    load(8'h55, 8'h3F, 8'h89, 8'h00, 8'h05);
    exec(len, halted);
    exec(len, halted);
    chk("sub_t3", cap[3], S_RAM_OE | S_B_IN | S_SUB);
    chk("sub_t4", cap[4], S_ALU_OE | S_A_IN | S_SUB);
    chk("sub_zf", zf_q, JEN);
    chk("sub_a", a, 0);
    exec(len, halted);
    chk("jz_t2", cap[2], JEN ? S_IR_OE | S_PC_LD : 15'h0);
    chk("jz_pc", pc, JEN ? 9 : 3);
    // 200+100 carries, JC taken; 1+1 does not, JC falls through
    load(8'h1E, 8'h2F, 8'h77, 8'd200, 8'd100);
    repeat (3) exec(len, halted);
    chk("jc_taken_t2", cap[2], JEN ? S_IR_OE | S_PC_LD : 15'h0);
    chk("jc_taken_pc", pc, JEN ? 7 : 3);
    load(8'h51, 8'h2F, 8'h77, 8'h00, 8'h01);
    exec(len, halted);
    exec(len, halted);
    chk("add_nc_cf", {zf_q, cf_q}, 0);
    exec(len, halted);
    chk("jc_not_t2", cap[2], JEN ? S_IR_OE : 15'h0);
    chk("jc_not_len", len, 3);
    chk("jc_not_pc", pc, 3);
    // HLT freezes at T2 until reset
    load(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    exec(len, halted);
    chk("hlt_seen", halted, 1);
    t = 0;
    repeat (10) begin
      if (step == 3'd2 && hlt) t++;
      @(negedge clk);
    end
    chk("hlt_frozen_cycles", t, 10);
    rst = 1'b1;
    #1;
    chk("hlt_rst", {hlt, step}, 0);
    // random programs against an instruction-level model
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF, 4'hA};
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = {ops[$urandom_range(0, 11)], 4'($urandom)};
      m = prog;
      ipc = 4'h0; ia = 8'h00; iout = 8'h00; iz = 1'b0; ic = 1'b0;
      do_reset();
      for (int k = 0; k < 25; k++) begin
        ins = m[ipc];
        ipc = ipc + 4'h1;
        n = ins[3:0];
        elen = 3;
        ih = 1'b0;
        case (ins[7:4])
          4'h1: begin ia = m[n]; elen = 4; end
          4'h2: begin t = int'(ia) + int'(m[n]); ic = t > 255; ia = 8'(t); iz = ia == 0; elen = 5; end
          4'h3: begin ic = ia < m[n]; ia = ia - m[n]; iz = ia == 0; elen = 5; end
          4'h4: begin m[n] = ia; elen = 4; end
          4'h5: ia = {4'h0, n};
          4'h6: if (JEN) ipc = n;
          4'h7: if (JEN && ic) ipc = n;
          4'h8: if (JEN && iz) ipc = n;
          4'hE: iout = ia;
          4'hF: ih = 1'b1;
          default: ;
        endcase
        exec(len, halted);
        chk("rnd_len", len, elen);
        if (ih) begin
          chk("rnd_halt", {halted, step}, {1'b1, 3'd2});
          break;
        end
        chk("rnd_a", a, ia);
        chk("rnd_out", out_r, iout);
        chk("rnd_pc", pc, ipc);
        chk("rnd_flags", {zf_q, cf_q}, JEN ? {iz, ic} : 2'b00);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
